// File: rtl/sram_pkg.sv
// Shared constants, width helper and init-FSM state names for the banked SRAM.
// The zero-init sweep is built only when SRAM_ZERO_INIT_EN is defined.
package sram_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    INIT = 1'b1
  } init_state_e;

  // Never returns 0, so a one-row or one-bank build still gets a 1-bit field.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// Two-entry response FIFO holding {err, data}; 1-bit pointers, 2-bit occupancy.
module sram_rsp_fifo #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] pop_data_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] slot_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   cnt_q;
  logic         do_push;
  logic         do_pop;

  assign full_o     = (cnt_q == 2'd2);
  assign empty_o    = (cnt_q == 2'd0);
  assign count_o    = cnt_q;
  assign pop_data_o = slot_q[rd_ptr_q];
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;

  // Slots are cleared so the data output reads zero straight out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_q[0] <= '0;
      slot_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      cnt_q     <= 2'd0;
    end else begin
      if (do_push) begin
        slot_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q         <= !wr_ptr_q;
      end
      if (do_pop) rd_ptr_q <= !rd_ptr_q;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/sram_bank_array.sv
// Multi-bank single-port SRAM with byte enables, range check and buffered reads.
// Define SRAM_ZERO_INIT_EN to zero every row after reset release.
module sram_bank_array
  import sram_pkg::*;
#(
  parameter int DATA_W  = 256,
  parameter int BANKS   = 32,
  parameter int DEPTH   = 1024,
  parameter int BANK_AW = clog2(BANKS),
  parameter int ROW_AW  = clog2(DEPTH),
  parameter int ADDR_W  = BANK_AW + ROW_AW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [DATA_W-1:0]        req_wdata,
  input  logic [DATA_W/BYTE_W-1:0] req_be,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     rsp_err,
  output logic                     init_busy,
  output logic [0:0]               dbg_init_state,
  output logic [1:0]               dbg_occ
);

  localparam int NBYTES = DATA_W / BYTE_W;

  logic [DATA_W-1:0]  mem_q [BANKS][DEPTH];
  logic [BANK_AW-1:0] bank;
  logic [ROW_AW-1:0]  row;
  logic [ROW_AW-1:0]  row_idx;
  logic               in_range;
  logic               accept;
  logic               wr_en;
  logic               rd_en;
  logic [DATA_W-1:0]  rd_word;
  logic [DATA_W:0]    fifo_out;
  logic               fifo_full;
  logic               fifo_empty;
  logic               wipe;
  logic [ROW_AW-1:0]  wipe_row;
  logic               init_ok;

  assign bank     = req_addr[BANK_AW-1:0];
  assign row      = req_addr[ADDR_W-1:BANK_AW];
  assign in_range = (32'(row) < DEPTH);
  assign row_idx  = in_range ? row : '0;

  // A request moves on a cycle where req_valid && req_ready; the requester holds
  // it stable until then. A response moves on rsp_valid && rsp_ready and stays
  // stable while rsp_ready is low.
  assign accept = req_valid && req_ready;
  assign wr_en  = accept && req_we && in_range;
  assign rd_en  = accept && !req_we;

`ifdef SRAM_ZERO_INIT_EN
  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_INIT = INIT;

  logic [0:0]        state_q, state_d;
  logic [ROW_AW-1:0] row_cnt_q, row_cnt_d;
  logic              init_done_q, init_done_d;

  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    init_done_d = init_done_q;
    case (state_q)
      ST_IDLE: begin
        if (!init_done_q) begin
          state_d   = ST_INIT;
          row_cnt_d = '0;
        end
      end
      ST_INIT: begin
        if (32'(row_cnt_q) == DEPTH - 1) begin
          state_d     = ST_IDLE;
          init_done_d = 1'b1;
        end else begin
          row_cnt_d = row_cnt_q + ROW_AW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      row_cnt_q   <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      init_done_q <= init_done_d;
    end
  end

  assign init_busy      = (state_q == ST_INIT);
  assign wipe           = init_busy;
  assign wipe_row       = row_cnt_q;
  assign dbg_init_state = state_q;
  // Also hold off the single cycle between reset release and entering INIT.
  assign init_ok        = init_done_q;
`else
  assign init_busy      = 1'b0;
  assign wipe           = 1'b0;
  assign wipe_row       = '0;
  assign dbg_init_state = IDLE;
  assign init_ok        = 1'b1;
`endif

  // Storage is deliberately not reset; only the sweep (when built) clears it.
  always_ff @(posedge clk) begin
    if (wipe) begin
      for (int b = 0; b < BANKS; b++) mem_q[b][wipe_row] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (req_be[i]) mem_q[bank][row_idx][i*BYTE_W +: BYTE_W] <= req_wdata[i*BYTE_W +: BYTE_W];
      end
    end
  end

  assign rd_word = mem_q[bank][row_idx];

  // The read result is captured into the FIFO at the accepting edge, giving one-cycle latency.
  sram_rsp_fifo #(
    .W (DATA_W + 1)
  ) u_rsp_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (rd_en),
    .push_data_i ({!in_range, (in_range ? rd_word : {DATA_W{1'b0}})}),
    .pop_i       (rsp_ready),
    .pop_data_o  (fifo_out),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (dbg_occ)
  );

  assign req_ready = init_ok && !init_busy && !fifo_full;
  assign rsp_valid = !fifo_empty;
  assign rsp_data  = fifo_out[DATA_W-1:0];
  assign rsp_err   = fifo_out[DATA_W];

endmodule

// File: tb/tb_sram_bank_array.sv
// Randomized scoreboard bench for sram_bank_array (small 4-bank, 12-row, 32-bit build).
module tb_sram_bank_array;

  localparam int DW    = 32;
  localparam int NB    = DW / 8;
  localparam int BANKS = 4;
  localparam int DEPTH = 12;
  localparam int BAW   = 2;
  localparam int AW    = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [NB-1:0] req_be = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic          init_busy;
  logic [0:0]    dbg_init_state;
  logic [1:0]    dbg_occ;

  int total = 0;
  int bad = 0;
  int occ = 0;
  int max_occ = 0;
  int rdy_mode = 0;
  int last_stalls = 0;
  bit acc_pend = 1'b0;
  bit in_reset = 1'b1;
  bit mon_pop;
  logic [DW:0]   exp_q[$];
  logic [DW-1:0] ref_mem [int];

  sram_bank_array #(
    .DATA_W (DW),
    .BANKS  (BANKS),
    .DEPTH  (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_be         (req_be),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .rsp_err        (rsp_err),
    .init_busy      (init_busy),
    .dbg_init_state (dbg_init_state),
    .dbg_occ        (dbg_occ)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: a word per address; out-of-range rows are dropped on write and error on read.
  function automatic void model_write(input int a, input logic [DW-1:0] d, input logic [NB-1:0] be);
    logic [DW-1:0] w;
    if ((a >> BAW) >= DEPTH) return;
    w = ref_mem.exists(a) ? ref_mem[a] : '0;
    for (int b = 0; b < NB; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
    ref_mem[a] = w;
  endfunction

  function automatic logic [DW:0] model_read(input int a);
    if ((a >> BAW) >= DEPTH) return {1'b1, {DW{1'b0}}};
    return {1'b0, ref_mem[a]};
  endfunction

  task automatic issue(input bit we, input int a, input logic [DW-1:0] d, input logic [NB-1:0] be);
    int stalls = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = AW'(a);
    req_wdata = d;
    req_be    = be;
    #1;
    while (!req_ready && stalls < 40) begin
      @(negedge clk);
      #1;
      stalls++;
    end
    last_stalls = stalls;
    if (!req_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout addr=%0d actual=stalled required=accept", a);
      req_valid = 1'b0;
      return;
    end
    if (we) model_write(a, d, be);
    else exp_q.push_back(model_read(a));
    acc_pend = !we;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    rdy_mode = 0;
    for (int c = 0; c < 40 && occ != 0; c++) @(negedge clk);
    @(negedge clk);
    #3;
    chk("drain_empty", occ, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #3;
    in_reset  = 1'b1;
    req_valid = 1'b0;
    rst       = 1'b0;
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_init_busy", init_busy, 0);
    chk("rst_occ", dbg_occ, 0);
    exp_q.delete();
    occ      = 0;
    acc_pend = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
`ifdef SRAM_ZERO_INIT_EN
    begin
      int busy = 0;
      int rdy_busy = 0;
      for (int c = 0; c < DEPTH + 8; c++) begin
        @(negedge clk);
        #1;
        if (init_busy) begin
          busy++;
          if (req_ready) rdy_busy++;
        end
      end
      chk("init_cycles", busy, DEPTH);
      chk("init_ready_low", rdy_busy, 0);
      for (int a = 0; a < BANKS * DEPTH; a++) ref_mem[a] = '0;
    end
`endif
    in_reset = 1'b0;
  endtask

  // Drives rsp_ready each cycle: 0 = always ready, 1 = stalled, other = random.
  initial begin
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       rsp_ready = 1'b1;
        1:       rsp_ready = 1'b0;
        default: rsp_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compares every presented response against the expected queue.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!in_reset) begin
        chk("rsp_valid", rsp_valid, occ > 0);
        chk("req_ready", req_ready, occ < 2);
        chk("occ", dbg_occ, occ);
        if (occ > 0 && exp_q.size() > 0) chk("rsp_err_data", {rsp_err, rsp_data}, exp_q[0]);
        mon_pop = (occ > 0) && rsp_ready;
        if (mon_pop && exp_q.size() > 0) void'(exp_q.pop_front());
        occ = occ + int'(acc_pend) - int'(mon_pop);
        acc_pend = 1'b0;
        if (occ > max_occ) max_occ = occ;
      end
    end
  end

  initial begin
    int sum;
    do_reset();

`ifdef SRAM_ZERO_INIT_EN
    in_reset = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("sweep_running", init_busy, 1);
    do_reset();
    issue(0, 5, 0, 0);
    issue(0, 47, 0, 0);
    drain();
`endif

    rdy_mode = 0;
    for (int a = 0; a < BANKS * DEPTH; a++) issue(1, a, $urandom, 4'hF);

    issue(1, 'h21, 32'hA5A5_A5A5, 4'hF);
    issue(0, 'h21, 0, 0);
    issue(1, 'h10, '1, 4'hF);
    issue(1, 'h10, 0, 4'h1);
    issue(0, 'h10, 0, 0);
    issue(1, 'h13, 32'h1234_5678, 4'h0);
    issue(0, 'h13, 0, 0);

    drain();
    rdy_mode = 1;
    issue(0, 3, 0, 0);
    issue(0, 7, 0, 0);
    fork
      issue(0, 11, 0, 0);
      begin
        repeat (4) @(negedge clk);
        rdy_mode = 0;
      end
    join
    chk("third_read_stalled", last_stalls > 0, 1);

    drain();
    max_occ = 0;
    sum = 0;
    for (int i = 0; i < 16; i++) begin
      issue(0, $urandom_range(0, 47), 0, 0);
      sum += last_stalls;
    end
    chk("stream_stalls", sum, 0);
    drain();
    chk("stream_max_occ", max_occ, 1);

    issue(1, 'h35, 32'hDEAD_BEEF, 4'hF);
    issue(0, 'h35, 0, 0);
    issue(0, 'h3F, 0, 0);
    issue(0, 'h01, 0, 0);
    drain();

    rdy_mode = 1;
    issue(0, 4, 0, 0);
    issue(0, 8, 0, 0);
    do_reset();
    rdy_mode = 0;
    issue(0, 4, 0, 0);
    issue(1, 9, 32'h0BAD_F00D, 4'b0110);
    issue(0, 9, 0, 0);
    drain();

    rdy_mode = 2;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) @(negedge clk);
      issue(1'($urandom_range(0, 1)), $urandom_range(0, 63), $urandom, NB'($urandom_range(0, 15)));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
